// File: rtl/pp_accumulator_8x8.sv
// pp_accumulator_8x8: multi-cycle adder summing the eight shifted partial products of an 8x8 multiply
module pp_accumulator_8x8 #(
   parameter int WIDTH        = 16,
   parameter int NUM_PP       = 8,
   parameter int PP_PER_CYCLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p0,
   input  logic [WIDTH-1:0] p1,
   input  logic [WIDTH-1:0] p2,
   input  logic [WIDTH-1:0] p3,
   input  logic [WIDTH-1:0] p4,
   input  logic [WIDTH-1:0] p5,
   input  logic [WIDTH-1:0] p6,
   input  logic [WIDTH-1:0] p7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
   output logic             busy
);

   localparam int IW = $clog2(NUM_PP);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] pin [NUM_PP];
   logic [WIDTH-1:0] hold [NUM_PP];
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] group_sum;
   logic [IW-1:0]    idx;

   // gather the partial-product ports into an indexable array
   always_comb begin
      pin[0] = p0;
      pin[1] = p1;
      pin[2] = p2;
      pin[3] = p3;
      pin[4] = p4;
      pin[5] = p5;
      pin[6] = p6;
      pin[7] = p7;
   end

   // sum of the group of held partial products starting at idx
   always_comb begin
      group_sum = '0;
      for (int k = 0; k < PP_PER_CYCLE; k++)
         group_sum = group_sum + hold[idx + IW'(k)];
   end

   // control FSM with registered handshake, status and product outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         idx       <= '0;
         product   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
         for (int i = 0; i < NUM_PP; i++)
            hold[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < NUM_PP; i++)
                     hold[i] <= pin[i];
                  acc      <= '0;
                  idx      <= '0;
                  state    <= ACCUM;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               acc <= acc + group_sum;
               idx <= idx + IW'(PP_PER_CYCLE);
               if (idx == IW'(NUM_PP - PP_PER_CYCLE))
                  state <= DONE;
            end
            DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  product   <= acc;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
